// File: rtl/divider_core.sv
// divider_core: sequential unsigned restoring divider, one quotient bit per clock.
// WIDTH_N-bit dividend / WIDTH_D-bit divisor -> WIDTH_N-bit quotient, WIDTH_D-bit remainder.
// Divide by zero returns quotient all ones, remainder = low dividend bits, div_by_zero=1.
// Optional macro DIVIDER_FAST_EXIT_EN: dividend < divisor finishes in one cycle (quotient 0).
// Requires 2 <= WIDTH_N and WIDTH_D <= WIDTH_N.
module divider_core #(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_D:0]   r_q, r_d;        // partial remainder, one guard bit
  logic [WIDTH_N-1:0] q_q, q_d;        // dividend shifting out / quotient shifting in
  logic [WIDTH_D-1:0] div_q, div_d;    // latched divisor
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_N-1:0] quot_q, quot_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor.
  // sh carries an extra top bit so the compare never loses a borrow.
  logic [WIDTH_D+1:0] sh;
  logic               ge;
  logic [WIDTH_D:0]   r_step;
  logic [WIDTH_N-1:0] q_step;
  logic               fast;

  assign sh     = {r_q, q_q[WIDTH_N-1]};
  assign ge     = sh >= {2'b00, div_q};
  assign r_step = ge ? (WIDTH_D+1)'(sh - {2'b00, div_q}) : (WIDTH_D+1)'(sh);
  assign q_step = {q_q[WIDTH_N-2:0], ge};

`ifdef DIVIDER_FAST_EXIT_EN
  assign fast = dividend < WIDTH_N'(divisor);
`else
  assign fast = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[WIDTH_D-1:0];
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dbz_d = 1'b0;
            if (fast) begin
              // dividend < divisor: the answer is known without iterating
              quot_d  = '0;
              rem_d   = dividend[WIDTH_D-1:0];
              state_d = S_DONE;
            end else begin
              div_d   = divisor;
              q_d     = dividend;
              r_d     = '0;
              cnt_d   = '0;
              state_d = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quot_d  = q_step;
          rem_d   = r_step[WIDTH_D-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule
